jt1943_fmbus_ctrl: RTL and testbench
====================================

JT1943_FMBUS_CTRL -- requirements
Module: jt1943_fmbus_ctrl

Interface
REQ-001 Parameter BUSY_ADDR, default 8'd2: recovery length in cen_fm ticks after an address-register write (a0=0).
REQ-002 Parameter BUSY_DATA, default 8'd12: recovery length in cen_fm ticks after a data-register write (a0=1).
REQ-003 clk  in  1  system clock, 24 MHz.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cen_cpu  in  1  sound CPU clock enable, 3 MHz.
REQ-006 cen_fm  in  1  FM chip clock enable, 1.5 MHz.
REQ-007 cpu_cs0 / cpu_cs1  in  1 each  CPU decode select for FM chip 0 / chip 1.
REQ-008 cpu_a0  in  1  register select; 0 = address, 1 = data.
REQ-009 cpu_wr_n / cpu_rd_n  in  1 each  CPU strobes, active-low.
REQ-010 cpu_dout  in  8  CPU write data.
REQ-011 cpu_din  out  8  read data returned to the CPU.
REQ-012 wait_n  out  1  CPU wait request, active-low.
REQ-013 fm_din  out  8  write data to both chips.
REQ-014 fm_a0  out  1  register select to both chips.
REQ-015 fm_cs0_n / fm_cs1_n  out  1 each  chip selects, active-low.
REQ-016 fm_wr_n  out  1  chip write strobe, active-low.
REQ-017 fm0_dout / fm1_dout  in  8 each  chip read data.
REQ-018 busy  out  1  high whenever the FSM is not IDLE or the recovery counter is non-zero.

Function
REQ-019 A request SHALL be detected on a cen_cpu cycle where (cpu_cs0|cpu_cs1) rises and either cpu_wr_n or cpu_rd_n is low; a held select SHALL NOT retrigger.
REQ-020 If cpu_cs0 and cpu_cs1 are high together, chip 0 SHALL be served and chip 1 ignored.
REQ-021 On detection, chip, a0, direction and cpu_dout SHALL be captured; wait_n SHALL go low on the next clk edge.
REQ-022 FSM states: IDLE, HOLDOFF, SYNC, STROBE, RECOVER.
REQ-023 IDLE -> HOLDOFF on request; HOLDOFF -> SYNC once the recovery counter is 0; SYNC -> STROBE on the next cen_fm.
REQ-024 STROBE SHALL last exactly one cen_fm period: selected fm_csX_n low, fm_wr_n low for writes and high for reads, fm_a0 and fm_din stable throughout.
REQ-025 At the cen_fm ending STROBE, reads SHALL latch the selected fmX_dout into cpu_din, and the counter SHALL load BUSY_ADDR (address write), BUSY_DATA (data write) or 0 (read).
REQ-026 RECOVER SHALL decrement the counter on each cen_fm and return to IDLE at 0.
REQ-027 The counter SHALL decrement on each cen_fm in every state and saturate at 0.
REQ-028 cpu_din SHALL hold its last read value until the next read completes.
REQ-029 A request arriving in RECOVER SHALL be captured and go to HOLDOFF.
REQ-030 Outside STROBE, fm_cs0_n, fm_cs1_n and fm_wr_n SHALL be 1.

Reset
REQ-031 On reset_n low, asynchronously: state IDLE, counter 0, wait_n=1, fm_cs0_n=fm_cs1_n=fm_wr_n=1, fm_a0=0, fm_din=0, cpu_din=0, busy=0.
REQ-032 A reset during STROBE SHALL deassert all chip strobes immediately, and the access SHALL be discarded.

Configuration
REQ-033 Macro JT1943_FMCTRL_POSTED_EN selects the write mode.
REQ-034 When defined, writes are posted: wait_n is released one clk after capture, and a new request arriving while busy=1 keeps wait_n low until the previous access leaves STROBE.
REQ-035 When undefined, wait_n stays low until the FSM returns to IDLE (recovery included).
REQ-036 Reads are non-posted in both modes: wait_n is released on the clk after cpu_din is latched.

Structure
REQ-037 A shared package jt1943_fmbus_pkg SHALL hold the FSM state enumeration and the default BUSY_ADDR/BUSY_DATA constants.
REQ-038 The recovery counter SHALL be a sub-module jt1943_fmbus_busycnt (load, cen_fm decrement, zero flag).

Verification
REQ-039 Write cs0, a0=0, data 8'h27 -> one STROBE with fm_cs0_n=0, fm_wr_n=0, fm_din=8'h27; counter loads 2; busy falls 2 cen_fm later.
REQ-040 Data write 8'h15 followed immediately by an address write -> second STROBE starts no earlier than 12 cen_fm after the first ends.
REQ-041 Read cs1 with fm1_dout=8'h80 -> cpu_din=8'h80 and wait_n released; fm_cs0_n stays 1.
REQ-042 cpu_cs0 and cpu_cs1 both high -> only fm_cs0_n pulses.
REQ-043 Write with macro defined -> wait_n low for exactly 1 clk; undefined -> low until busy=0.
REQ-044 reset_n pulsed low mid-STROBE -> all strobes 1 in the same cycle, wait_n=1, next access executes normally.

Source files
------------

// File: rtl/jt1943_fmbus_pkg.sv
// -----------------------------------------------------------------------------
// jt1943_fmbus_pkg
// Shared definitions for the 1943 sound-CPU to FM-chip bus controller:
//   - fmbus_state_e : access sequencer states
//   - BUSY_ADDR_DEF : default recovery (cen_fm ticks) after an address write
//   - BUSY_DATA_DEF : default recovery (cen_fm ticks) after a data write
// -----------------------------------------------------------------------------
package jt1943_fmbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,  // no access in flight
    ST_HOLDOFF = 3'd1,  // access captured, waiting for chip recovery to expire
    ST_SYNC    = 3'd2,  // waiting for the next cen_fm to align the strobe
    ST_STROBE  = 3'd3,  // chip select (and write strobe) asserted for one cen_fm period
    ST_RECOVER = 3'd4   // recovery counter running after the strobe
  } fmbus_state_e;

  localparam logic [7:0] BUSY_ADDR_DEF = 8'd2;
  localparam logic [7:0] BUSY_DATA_DEF = 8'd12;

  // Recovery length to load at the end of a strobe.
  function automatic logic [7:0] recovery_len(input logic is_wr, input logic a0,
                                              input logic [7:0] busy_addr,
                                              input logic [7:0] busy_data);
    if (!is_wr)  return 8'd0;
    else if (a0) return busy_data;
    else         return busy_addr;
  endfunction

endpackage

// File: rtl/jt1943_fmbus_busycnt.sv
// -----------------------------------------------------------------------------
// jt1943_fmbus_busycnt
// FM chip recovery counter. Loads a recovery length, counts down once per
// cen_fm tick and saturates at zero.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   cen_i          : FM clock enable (decrement tick)
//   load_i         : load load_val_i (takes priority over the decrement)
//   load_val_i     : recovery length
//   zero_o         : counter is zero
//   one_o          : counter is one (next tick reaches zero)
// -----------------------------------------------------------------------------
module jt1943_fmbus_busycnt (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cen_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o,
  output logic       one_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (cen_i && (cnt_q != 8'd0))
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= 8'd0;
    else          cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 8'd0);
  assign one_o  = (cnt_q == 8'd1);

endmodule

// File: rtl/jt1943_fmbus_ctrl.sv
// -----------------------------------------------------------------------------
// jt1943_fmbus_ctrl
// Bridges the 3 MHz sound CPU to two FM chips running at 1.5 MHz. A CPU
// access is captured on a cen_cpu cycle, aligned to cen_fm, presented to the
// chips as a one-cen_fm-period strobe, and followed by the chip's recovery
// time (BUSY_ADDR after an address write, BUSY_DATA after a data write).
//
// Build option:
//   JT1943_FMCTRL_POSTED_EN defined   : writes are posted (wait_n low one clk)
//   JT1943_FMCTRL_POSTED_EN undefined : every access holds wait_n low until
//                                       the sequencer is idle again
//
// Ports:
//   clk, reset_n          : 24 MHz clock, asynchronous active-low reset
//   cen_cpu, cen_fm       : CPU (3 MHz) and FM (1.5 MHz) clock enables
//   cpu_cs0/1, cpu_a0     : CPU chip decode and register select
//   cpu_wr_n, cpu_rd_n    : CPU strobes (active low)
//   cpu_dout / cpu_din    : CPU write data / read data back to CPU
//   wait_n                : CPU wait request (active low)
//   fm_din, fm_a0         : data and register select to both chips
//   fm_cs0_n, fm_cs1_n    : chip selects (active low)
//   fm_wr_n               : chip write strobe (active low)
//   fm0_dout, fm1_dout    : chip read data
//   busy                  : access in flight or recovery pending
//   st_dbg                : current sequencer state
// -----------------------------------------------------------------------------
module jt1943_fmbus_ctrl
  import jt1943_fmbus_pkg::*;
#(
  parameter logic [7:0] BUSY_ADDR = BUSY_ADDR_DEF,
  parameter logic [7:0] BUSY_DATA = BUSY_DATA_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cen_cpu,
  input  logic         cen_fm,
  input  logic         cpu_cs0,
  input  logic         cpu_cs1,
  input  logic         cpu_a0,
  input  logic         cpu_wr_n,
  input  logic         cpu_rd_n,
  input  logic [7:0]   cpu_dout,
  output logic [7:0]   cpu_din,
  output logic         wait_n,
  output logic [7:0]   fm_din,
  output logic         fm_a0,
  output logic         fm_cs0_n,
  output logic         fm_cs1_n,
  output logic         fm_wr_n,
  input  logic [7:0]   fm0_dout,
  input  logic [7:0]   fm1_dout,
  output logic         busy,
  output fmbus_state_e st_dbg
);

  // CPU handshake: an access is accepted on the clk edge where a request is
  // detected; wait_n drops on that same edge and the CPU must hold its strobes
  // until wait_n returns high. A request is a rising edge of the combined
  // select seen on cen_cpu cycles with either CPU strobe low, so a select held
  // across several CPU cycles counts once.

  fmbus_state_e state_q, state_d;

  logic       sel, sel_prev_q, req;
  logic       wait_q, wait_d;

  // Access being executed. Only changes in IDLE/RECOVER, so the chip-facing
  // outputs stay stable for the whole strobe.
  logic       acc_chip_q;   // 0 = chip 0, 1 = chip 1
  logic       acc_a0_q;
  logic       acc_wr_q;
  logic [7:0] acc_data_q;

  // A request that arrived while an access was still heading to or inside
  // its strobe. It is promoted once the sequencer is past the strobe.
  logic       pend_vld_q;
  logic       pend_chip_q;
  logic       pend_a0_q;
  logic       pend_wr_q;
  logic [7:0] pend_data_q;

  logic [7:0] cpu_din_q;

  logic       take_new, store_pend, promote, rd_latch;
  logic       cnt_load;
  logic [7:0] cnt_val;
  logic       cnt_zero, cnt_one;

  // chip 0 wins when both selects are high
  logic       req_chip;

  assign sel      = cpu_cs0 | cpu_cs1;
  assign req      = cen_cpu & sel & ~sel_prev_q & (~cpu_wr_n | ~cpu_rd_n);
  assign req_chip = ~cpu_cs0;

  jt1943_fmbus_busycnt u_busycnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .cen_i      (cen_fm),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero),
    .one_o      (cnt_one)
  );

  // ---------------------------------------------------------------------------
  // Sequencer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    take_new   = 1'b0;
    store_pend = 1'b0;
    promote    = 1'b0;
    rd_latch   = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = 8'd0;

    case (state_q)
      ST_IDLE: begin
        if (pend_vld_q) begin
          promote = 1'b1;
          state_d = ST_HOLDOFF;
        end else if (req) begin
          take_new = 1'b1;
          state_d  = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        if (cnt_zero) state_d = ST_SYNC;
      end

      ST_SYNC: begin
        if (cen_fm) state_d = ST_STROBE;
      end

      ST_STROBE: begin
        // entered on a cen_fm edge, left on the next one: one full FM period
        if (cen_fm) begin
          state_d  = ST_RECOVER;
          cnt_load = 1'b1;
          cnt_val  = recovery_len(acc_wr_q, acc_a0_q, BUSY_ADDR, BUSY_DATA);
          rd_latch = ~acc_wr_q;
        end
      end

      ST_RECOVER: begin
        if (pend_vld_q) begin
          promote = 1'b1;
          state_d = ST_HOLDOFF;
        end else if (req) begin
          take_new = 1'b1;
          state_d  = ST_HOLDOFF;
        end else if (cnt_zero || (cen_fm && cnt_one)) begin
          // leave on the tick that empties the counter so busy falls with it
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Requests that cannot be taken yet are parked; a second one while a
    // request is already parked is not expected (the CPU is held in wait).
    if (req && !pend_vld_q &&
        ((state_q == ST_HOLDOFF) || (state_q == ST_SYNC) || (state_q == ST_STROBE)))
      store_pend = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // CPU wait request
  // ---------------------------------------------------------------------------
  always_comb begin
    wait_d = wait_q;
`ifdef JT1943_FMCTRL_POSTED_EN
    // Writes release one clk after they become the active access; reads wait
    // for the clk after cpu_din is latched (first RECOVER cycle).
    if (!pend_vld_q &&
        (((state_q == ST_HOLDOFF) && acc_wr_q) ||
         ((state_q == ST_RECOVER) && !acc_wr_q)))
      wait_d = 1'b1;
`else
    // Release together with the return to IDLE; for reads this is the clk
    // after the latch because their recovery length is zero.
    if (!pend_vld_q && (state_q == ST_RECOVER) && (state_d == ST_IDLE))
      wait_d = 1'b1;
`endif
    if (take_new || store_pend || promote)
      wait_d = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sel_prev_q  <= 1'b0;
      wait_q      <= 1'b1;
      acc_chip_q  <= 1'b0;
      acc_a0_q    <= 1'b0;
      acc_wr_q    <= 1'b0;
      acc_data_q  <= 8'd0;
      pend_vld_q  <= 1'b0;
      pend_chip_q <= 1'b0;
      pend_a0_q   <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_data_q <= 8'd0;
      cpu_din_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;

      if (cen_cpu) sel_prev_q <= sel;

      if (take_new) begin
        acc_chip_q <= req_chip;
        acc_a0_q   <= cpu_a0;
        acc_wr_q   <= ~cpu_wr_n;
        acc_data_q <= cpu_dout;
      end else if (promote) begin
        acc_chip_q <= pend_chip_q;
        acc_a0_q   <= pend_a0_q;
        acc_wr_q   <= pend_wr_q;
        acc_data_q <= pend_data_q;
      end

      if (store_pend) begin
        pend_vld_q  <= 1'b1;
        pend_chip_q <= req_chip;
        pend_a0_q   <= cpu_a0;
        pend_wr_q   <= ~cpu_wr_n;
        pend_data_q <= cpu_dout;
      end else if (promote) begin
        pend_vld_q <= 1'b0;
      end

      if (rd_latch)
        cpu_din_q <= acc_chip_q ? fm1_dout : fm0_dout;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. Strobes decode straight from the state register so an
  // asynchronous reset drops them immediately.
  // ---------------------------------------------------------------------------
  assign fm_cs0_n = ~((state_q == ST_STROBE) & ~acc_chip_q);
  assign fm_cs1_n = ~((state_q == ST_STROBE) &  acc_chip_q);
  assign fm_wr_n  = ~((state_q == ST_STROBE) &  acc_wr_q);
  assign fm_a0    = acc_a0_q;
  assign fm_din   = acc_data_q;
  assign cpu_din  = cpu_din_q;
  assign wait_n   = wait_q;
  assign busy     = (state_q != ST_IDLE) | ~cnt_zero;
  assign st_dbg   = state_q;

endmodule

// File: tb/tb_jt1943_fmbus_ctrl.sv
module tb_jt1943_fmbus_ctrl;
  import jt1943_fmbus_pkg::*;

`ifdef JT1943_FMCTRL_POSTED_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  // ---------------- clock / reset / enables ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cen_cpu = 1'b0;
  logic cen_fm = 1'b0;
  int   div = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    div++;
    cen_cpu = ((div % 8) == 0);
    cen_fm  = ((div % 16) == 0);
  end

  // ---------------- DUT ----------------
  logic       cpu_cs0 = 1'b0, cpu_cs1 = 1'b0, cpu_a0 = 1'b0;
  logic       cpu_wr_n = 1'b1, cpu_rd_n = 1'b1;
  logic [7:0] cpu_dout = 8'd0, fm0_dout = 8'd0, fm1_dout = 8'd0;
  logic [7:0] cpu_din, fm_din;
  logic       wait_n, fm_a0, fm_cs0_n, fm_cs1_n, fm_wr_n, busy;
  fmbus_state_e st_dbg;

  jt1943_fmbus_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cen_cpu(cen_cpu), .cen_fm(cen_fm),
    .cpu_cs0(cpu_cs0), .cpu_cs1(cpu_cs1), .cpu_a0(cpu_a0),
    .cpu_wr_n(cpu_wr_n), .cpu_rd_n(cpu_rd_n), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .wait_n(wait_n), .fm_din(fm_din), .fm_a0(fm_a0),
    .fm_cs0_n(fm_cs0_n), .fm_cs1_n(fm_cs1_n), .fm_wr_n(fm_wr_n),
    .fm0_dout(fm0_dout), .fm1_dout(fm1_dout), .busy(busy), .st_dbg(st_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];     // {fm_cs0_n, fm_cs1_n, fm_wr_n, fm_a0, fm_din} per strobe
  logic [7:0]  rsp_q[$];     // cpu_din expected at each wait_n release
  int          st_start[$];
  int          st_end[$];
  int          busy_fall_cyc = 0;
  bit          skip = 1'b0;
  logic [7:0]  last_rd = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // strobe monitor
  logic [11:0] st_cur, st_snap;
  bit          st_act = 1'b0;
  bit          st_bad = 1'b0;
  int          st_len = 0;
  int          st_t0 = 0;

  always @(negedge clk) begin
    st_cur = {fm_cs0_n, fm_cs1_n, fm_wr_n, fm_a0, fm_din};
    if (!fm_cs0_n || !fm_cs1_n) begin
      if (!st_act) begin
        st_act = 1'b1; st_len = 1; st_bad = 1'b0; st_snap = st_cur; st_t0 = cyc;
        if (exp_q.size() == 0) fail("unexpected_strobe");
        else check("strobe_fields", st_snap, exp_q.pop_front());
      end else begin
        st_len++;
        if (st_cur !== st_snap) st_bad = 1'b1;
      end
    end else if (st_act) begin
      st_act = 1'b0;
      st_start.push_back(st_t0);
      st_end.push_back(cyc);
      if (!skip) begin
        check("strobe_len", st_len, 16);
        check("strobe_stable", st_bad, 0);
      end
    end
  end

  // wait release / busy monitor
  logic wait_prev = 1'b1;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (wait_n && !wait_prev && !skip) begin
      if (rsp_q.size() == 0) fail("unexpected_release");
      else check("cpu_din_at_release", cpu_din, rsp_q.pop_front());
    end
    if (!busy && busy_prev) busy_fall_cyc = cyc;
    wait_prev = wait_n;
    busy_prev = busy;
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_access(input logic cs0, input logic cs1, input logic a0,
                            input logic wr, input logic [7:0] d,
                            input int hold, input bit queued);
    int  low;
    bit  seen;
    exp_q.push_back({~cs0, cs0, ~wr, a0, d});
    if (!wr) last_rd = cs0 ? fm0_dout : fm1_dout;
    rsp_q.push_back(last_rd);
    @(negedge clk);
    cpu_cs0 = cs0; cpu_cs1 = cs1; cpu_a0 = a0;
    cpu_wr_n = ~wr; cpu_rd_n = wr; cpu_dout = d;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (!wait_n) seen = 1'b1;
    end
    if (!seen) begin
      fail("wait_assert_timeout");
    end else begin
      low = 0;
      while (!wait_n && low < 2000) begin
        low++;
        @(negedge clk);
      end
      if (!wait_n) fail("wait_release_timeout");
      else if (POSTED && wr && !queued) check("posted_wait_low", low, 1);
      else if (POSTED && wr && queued) check("queued_wait_low", (low > 1), 1);
      else check("release_busy", busy, 0);
    end
    repeat (hold) @(negedge clk);
    cpu_cs0 = 1'b0; cpu_cs1 = 1'b0; cpu_wr_n = 1'b1; cpu_rd_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 600) begin
      n++;
      @(negedge clk);
    end
    if (busy) fail("busy_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #22;
    check("rst_wait_n", wait_n, 1);
    check("rst_strobes", {fm_cs0_n, fm_cs1_n, fm_wr_n}, 3'b111);
    check("rst_fm_a0", fm_a0, 0);
    check("rst_fm_din", fm_din, 0);
    check("rst_cpu_din", cpu_din, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // address write to chip 0, recovery 2 cen_fm
    cpu_access(1'b1, 1'b0, 1'b0, 1'b1, 8'h27, 4, 1'b0);
    wait_idle();
    check("addr_recovery", busy_fall_cyc - st_end[$], 32);

    // read chip 1, then chip 0
    fm0_dout = 8'h5A; fm1_dout = 8'h80;
    cpu_access(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4, 1'b0);
    wait_idle();
    cpu_access(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4, 1'b0);
    wait_idle();

    // both selects high: chip 0 only; data write, recovery 12 cen_fm;
    // cpu_din keeps the last read value
    cpu_access(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 4, 1'b0);
    wait_idle();
    check("data_recovery", busy_fall_cyc - st_end[$], 192);

    // data write immediately followed by an address write
    cpu_access(1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 4, 1'b0);
    cpu_access(1'b1, 1'b0, 1'b0, 1'b1, 8'h8E, 4, 1'b0);
    wait_idle();
    if (POSTED) check("b2b_gap", st_start[$] - st_end[$-1], 208);
    else        check("b2b_gap_min", (st_start[$] - st_end[$-1]) >= 192, 1);

    // select held for many CPU cycles must not retrigger
    cpu_access(1'b0, 1'b1, 1'b0, 1'b1, 8'hC3, 40, 1'b0);
    wait_idle();

    // second write issued right after the first is released
    cpu_access(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 0, 1'b0);
    cpu_access(1'b0, 1'b1, 1'b1, 1'b1, 8'h22, 0, POSTED);
    wait_idle();

    // reset in the middle of a strobe
    skip = 1'b1;
    exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, 8'h5C});
    @(negedge clk);
    cpu_cs0 = 1'b1; cpu_a0 = 1'b1; cpu_wr_n = 1'b0; cpu_dout = 8'h5C;
    for (int i = 0; i < 300 && fm_cs0_n; i++) @(negedge clk);
    if (fm_cs0_n) fail("strobe_before_reset_timeout");
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_strobes", {fm_cs0_n, fm_cs1_n, fm_wr_n}, 3'b111);
    check("mid_rst_wait_n", wait_n, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cpu_din", cpu_din, 0);
    last_rd = 8'd0;
    @(negedge clk);
    cpu_cs0 = 1'b0; cpu_a0 = 1'b0; cpu_wr_n = 1'b1; cpu_dout = 8'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    skip = 1'b0;

    // normal accesses after reset
    cpu_access(1'b0, 1'b1, 1'b0, 1'b1, 8'hA5, 4, 1'b0);
    wait_idle();
    fm1_dout = 8'h7E;
    cpu_access(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 4, 1'b0);
    wait_idle();

    repeat (20) @(negedge clk);
    check("strobes_all_seen", exp_q.size(), 0);
    check("releases_all_seen", rsp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #800000;
    fail("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
